// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the single-port DM port of dm_arbiter.
// The arbiter connects through the slave modport; whatever drives requests and
// models the DM connects through the master modport.
interface dm_arbiter_if;
    // requester 0 (CPU load/store)
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    // requester 1 (debug/DMA)
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    // shared single-port DM, combinational read
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wd,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output dm_we, dm_addr, dm_wd,
        input  dm_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wd,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  dm_we, dm_addr, dm_wd,
        output dm_rd
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction is IDLE -> ACCESS -> RESP, three cycles, one at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting; requests sampled, winner's command latched on exit
//   ACCESS | winner granted, DM driven from the latched command, read captured
//   RESP   | winner sees rvalid/err/rdata for one cycle, pointer updated
module dm_arbiter #(
    parameter int unsigned DM_WORDS = 1024
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    dm_arbiter_if.slave   bus,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // one past the last legal byte address; 33 bits so DM_WORDS*4 never wraps
    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic        last_q, last_d;       // last-granted requester
    logic        win_q, win_d;         // requester owning the current transaction
    logic        cmd_we_q, cmd_we_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wd_q, cmd_wd_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        any_req;
    logic        win_sel;
    logic        cmd_err;
    logic [31:0] rd_capture;

    assign any_req = bus.m0_req | bus.m1_req;

    // Misaligned or out-of-range addresses error out; computed from the latched
    // command so it is stable across ACCESS and RESP.
    assign cmd_err = (cmd_addr_q[1:0] != 2'b00) || ({1'b0, cmd_addr_q} >= DM_BYTES);

    // Read data to capture: only a legal read takes the DM value.
    assign rd_capture = (!cmd_we_q && !cmd_err) ? bus.dm_rd : 32'h0;

    // Winner selection: single request wins outright, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        win_sel = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            win_sel = ~last_q;
        end else begin
            win_sel = bus.m1_req;
        end
    end

    // State, pointer, command and read-data registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            win_q      <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= 32'h0;
            cmd_wd_q   <= 32'h0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_wd_q   <= cmd_wd_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Next-state logic: latch command on leaving IDLE, capture read in ACCESS,
    // move the round-robin pointer in RESP.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_wd_d   = cmd_wd_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = ACCESS;
                    win_d      = win_sel;
                    cmd_we_d   = win_sel ? bus.m1_we   : bus.m0_we;
                    cmd_addr_d = win_sel ? bus.m1_addr : bus.m0_addr;
                    cmd_wd_d   = win_sel ? bus.m1_wd   : bus.m0_wd;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (win_q) begin
                    rdata1_d = rd_capture;
                end else begin
                    rdata0_d = rd_capture;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = win_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only, so an async reset
    // clears dm_we and every strobe in the same cycle.
    always_comb begin
        bus.m0_gnt    = 1'b0;
        bus.m1_gnt    = 1'b0;
        bus.m0_rvalid = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.m0_err    = 1'b0;
        bus.m1_err    = 1'b0;
        bus.m0_rdata  = 32'h0;
        bus.m1_rdata  = 32'h0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h0;
        bus.dm_wd     = 32'h0;
        if (state_q == ACCESS) begin
            bus.m0_gnt  = ~win_q;
            bus.m1_gnt  = win_q;
            bus.dm_we   = cmd_we_q & ~cmd_err;
            bus.dm_addr = cmd_addr_q;
            bus.dm_wd   = cmd_wd_q;
        end else if (state_q == RESP) begin
            bus.m0_rvalid = ~win_q;
            bus.m1_rvalid = win_q;
            bus.m0_err    = ~win_q & cmd_err;
            bus.m1_err    = win_q & cmd_err;
            bus.m0_rdata  = win_q ? 32'h0 : rdata0_q;
            bus.m1_rdata  = win_q ? rdata1_q : 32'h0;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule
